// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and a
// constant log2 helper used to size the amount field and the stage count.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Ceiling log2; for the power-of-two widths used here this is exact.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the barrel shifter. It applies mux levels
// FIRST_LEVEL .. FIRST_LEVEL+LEVELS-1 to the incoming word and holds its
// contents whenever the downstream side cannot take them.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHAMT_W     = 5,
    parameter int FIRST_LEVEL = 0,
    parameter int LEVELS      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] amt_i,
    input  shift_op_e          op_i,
    input  logic               fill_i,
    input  logic               ovs_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] amt_o,
    output shift_op_e          op_o,
    output logic               fill_o,
    output logic               ovs_o,
    output logic               zero_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic                     valid_q;
    logic [WIDTH-1:0]         data_q, data_d;
    logic [SHAMT_W-1:0]       amt_q;
    shift_op_e                op_q;
    logic                     fill_q, ovs_q, zero_q, zero_d;
    logic [LEVELS:0][WIDTH-1:0] lvl_data;

    assign lvl_data[0] = data_i;

    for (genvar g = 0; g < LEVELS; g++) begin : g_level
        localparam int SH = 1 << (FIRST_LEVEL + g);
        logic [WIDTH-1:0] src, res;

        assign src = lvl_data[g];

        // Single mux level: shift or rotate by SH when this amount bit is set.
        always_comb begin
            res = src;
            if (amt_i[FIRST_LEVEL + g]) begin
                case (op_i)
                    SHIFT_SLL: res = src << SH;
                    SHIFT_SRL: res = src >> SH;
                    SHIFT_SRA: res = (src >> SH) | ({WIDTH{fill_i}} & ~(ONES >> SH));
                    SHIFT_ROR: res = (src >> SH) | (src << (WIDTH - SH));
                    default:   res = src;
                endcase
            end
        end

        assign lvl_data[g+1] = res;
    end

    // Oversize forces the fill pattern; applying it in every stage is
    // idempotent, so the flag only needs to travel alongside the data.
    assign data_d  = (ovs_i && (op_i != SHIFT_ROR)) ? {WIDTH{fill_i}} : lvl_data[LEVELS];
    assign zero_d  = (data_d == '0);
    assign ready_o = !valid_q || ready_i;

    // Stage register: load when free or draining, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            op_q    <= SHIFT_SLL;
            fill_q  <= 1'b0;
            ovs_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (ready_o) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                op_q   <= op_i;
                fill_q <= fill_i;
                ovs_q  <= ovs_i;
                zero_q <= zero_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign op_o    = op_q;
    assign fill_o  = fill_q;
    assign ovs_o   = ovs_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides. Stage 0 decode
// (fill bit, oversize flag, effective amount) happens here; the shift levels
// are spread over NSTAGE bubble-collapsing registered stages.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int SHAMT_IN_W       = 32,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [WIDTH-1:0]      D,
    input  logic [SHAMT_IN_W-1:0] S,
    input  logic [1:0]            OP,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [WIDTH-1:0]      Y,
    output logic                  Z
);

    localparam int SHAMT_W = clog2_f(WIDTH);
    localparam int NSTAGE  = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Index k is the input of stage k; index NSTAGE is the pipeline output.
    logic               vld_s  [0:NSTAGE];
    logic               rdy_s  [0:NSTAGE];
    logic [WIDTH-1:0]   data_s [0:NSTAGE];
    logic [SHAMT_W-1:0] amt_s  [0:NSTAGE];
    shift_op_e          op_s   [0:NSTAGE];
    logic               fill_s [0:NSTAGE];
    logic               ovs_s  [0:NSTAGE];
    logic [NSTAGE-1:0]  zero_s;
    logic               oversize;

    // WIDTH is a power of two, so S >= WIDTH is exactly "any bit above the
    // effective amount is set".
    if (SHAMT_IN_W > SHAMT_W) begin : g_ovs
        assign oversize = |S[SHAMT_IN_W-1:SHAMT_W];
    end else begin : g_no_ovs
        assign oversize = 1'b0;
    end

    assign vld_s[0]      = IN_VALID;
    assign data_s[0]     = D;
    assign amt_s[0]      = S[SHAMT_W-1:0];
    assign op_s[0]       = shift_op_e'(OP);
    assign fill_s[0]     = (op_s[0] == SHIFT_SRA) && D[WIDTH-1];
    assign ovs_s[0]      = oversize;
    assign rdy_s[NSTAGE] = OUT_READY;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int FIRST = k * LEVELS_PER_STAGE;
        localparam int LV    = ((SHAMT_W - FIRST) < LEVELS_PER_STAGE) ?
                               (SHAMT_W - FIRST) : LEVELS_PER_STAGE;

        shift_stage #(
            .WIDTH       (WIDTH),
            .SHAMT_W     (SHAMT_W),
            .FIRST_LEVEL (FIRST),
            .LEVELS      (LV)
        ) u_stage (
            .clk_i   (CLK),
            .rst_i   (RST),
            .valid_i (vld_s[k]),
            .ready_o (rdy_s[k]),
            .data_i  (data_s[k]),
            .amt_i   (amt_s[k]),
            .op_i    (op_s[k]),
            .fill_i  (fill_s[k]),
            .ovs_i   (ovs_s[k]),
            .valid_o (vld_s[k+1]),
            .ready_i (rdy_s[k+1]),
            .data_o  (data_s[k+1]),
            .amt_o   (amt_s[k+1]),
            .op_o    (op_s[k+1]),
            .fill_o  (fill_s[k+1]),
            .ovs_o   (ovs_s[k+1]),
            .zero_o  (zero_s[k])
        );
    end

    assign IN_READY  = rdy_s[0] && !RST;
    assign OUT_VALID = vld_s[NSTAGE];
    assign Y         = data_s[NSTAGE];
    assign Z         = zero_s[NSTAGE-1];

    // Side-band fields leaving the last stage and the zero flags of inner
    // stages have no consumer.
    logic unused_tail;
    assign unused_tail = ^{amt_s[NSTAGE], op_s[NSTAGE], fill_s[NSTAGE], ovs_s[NSTAGE], zero_s};

endmodule
